// File: rtl/proximity_zone_detector.sv
// Proximity zone classifier: FAR / EXPECT / PET with hysteresis,
// N-sample confirmation and a stale-sample timeout.
module proximity_zone_detector #(
  parameter int DIST_W      = 20,
  parameter int NEAR_TH     = 511,
  parameter int FAR_TH      = 1279,
  parameter int HYST        = 32,
  parameter int CONFIRM     = 3,
  parameter int TIMEOUT_CYC = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] distance,
  input  logic              dist_valid,
  output logic [1:0]        zone,
  output logic              petting,
  output logic              expecting,
  output logic              zone_change,
  output logic              stale
);

  typedef enum logic [1:0] {
    FAR    = 2'd0,
    EXPECT = 2'd1,
    PET    = 2'd2
  } zone_t;

  localparam int CW = $clog2(CONFIRM + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DIST_W:0] NEAR_LO = (DIST_W+1)'(NEAR_TH);
  localparam logic [DIST_W:0] NEAR_HI = (DIST_W+1)'(NEAR_TH + HYST);
  localparam logic [DIST_W:0] FAR_LO  = (DIST_W+1)'(FAR_TH);
  localparam logic [DIST_W:0] FAR_HI  = (DIST_W+1)'(FAR_TH + HYST);
  localparam logic [CW-1:0]   CONF_V  = CW'(CONFIRM);
  localparam logic [TW-1:0]   TMO_V   = TW'(TIMEOUT_CYC);

  zone_t           zone_q, zone_d;
  zone_t           cand_q, cand_d;
  zone_t           cls;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            stale_q, stale_d;
  logic            chg_q, chg_d;
  logic            accept;
  logic [DIST_W:0] d_ext;

  // Zero distance means no echo and is dropped entirely
  assign accept = dist_valid && (distance != '0);
  assign d_ext  = {1'b0, distance};

  // Candidate zone for the current sample, with hysteresis on exit
  always_comb begin
    cls = FAR;
    if (d_ext < NEAR_LO || (zone_q == PET && d_ext < NEAR_HI))
      cls = PET;
    else if (d_ext < FAR_LO || (zone_q != FAR && d_ext < FAR_HI))
      cls = EXPECT;
  end

  // Next-state: confirmation, commit and timeout handling
  always_comb begin
    zone_d  = zone_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    stale_d = stale_q;
    chg_d   = 1'b0;
    cnt_inc = '0;
    if (accept) begin
      tcnt_d  = '0;
      stale_d = 1'b0;
      if (cls == zone_q) begin
        cnt_d = '0;
      end else begin
        if (cls != cand_q) begin
          cand_d  = cls;
          cnt_inc = CW'(1);
        end else begin
          cnt_inc = (cnt_q >= CONF_V) ? cnt_q : cnt_q + 1'b1;
        end
        if (cnt_inc >= CONF_V) begin
          zone_d = cls;
          cnt_d  = '0;
          chg_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end else if (tcnt_q != TMO_V) begin
      tcnt_d = tcnt_q + 1'b1;
      if (tcnt_d == TMO_V) begin
        stale_d = 1'b1;
        zone_d  = FAR;
        cnt_d   = '0;
        chg_d   = (zone_q != FAR);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zone_q  <= FAR;
      cand_q  <= FAR;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      stale_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      zone_q  <= zone_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      stale_q <= stale_d;
      chg_q   <= chg_d;
    end
  end

  assign zone        = zone_q;
  assign petting     = (zone_q == PET);
  assign expecting   = (zone_q == PET) || (zone_q == EXPECT);
  assign zone_change = chg_q;
  assign stale       = stale_q;

endmodule

// File: doc/proximity_zone_detector.md
Name: proximity_zone_detector

Overview:
- Parametrised successor to the fixed two-threshold distance compare that drives the petting/expecting flags.
- Classifies each distance sample from the ultrasonic front-end (sonic_top) into FAR / EXPECT / PET zones.
- Adds hysteresis, N-sample confirmation (debounce) and a stale-sample timeout.
- Sits between sonic_top and the behaviour logic; petting/expecting remain as compatibility outputs.

Parameters:
- DIST_W, 20, width of distance input.
- NEAR_TH, 511, enter PET when distance < NEAR_TH.
- FAR_TH, 1279, enter EXPECT when distance < FAR_TH; must satisfy FAR_TH > NEAR_TH.
- HYST, 32, extra margin required to leave a closer zone.
- CONFIRM, 3, consecutive agreeing samples needed to change zone; must be >= 1.
- TIMEOUT_CYC, 10000000, clk cycles without an accepted sample before the zone is forced to FAR.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- distance  in  DIST_W  latest measured distance.
- dist_valid  in  1  one-cycle strobe; distance is valid in that cycle.
- zone  out  2  committed zone: 0 = FAR, 1 = EXPECT, 2 = PET (3 never driven).
- petting  out  1  zone == PET.
- expecting  out  1  zone == EXPECT or zone == PET.
- zone_change  out  1  one-cycle pulse in the cycle zone takes a new value.
- stale  out  1  high while the timeout has expired and no sample has been accepted since.

Behaviour:
- Reset (async, any time, including mid-confirmation):
  - zone = FAR; petting = expecting = zone_change = 0; stale = 0.
  - Candidate register = FAR; confirm counter = 0; timeout counter = 0.
- Accepted sample: dist_valid = 1 and distance != 0. Distance 0 (sensor no-echo) is ignored entirely: no classification, and it does not restart the timeout.
- Candidate classification per accepted sample, given current zone Z and distance d. Sums are computed at DIST_W+1 bits so they never overflow.
  - PET if d < NEAR_TH, or if Z == PET and d < NEAR_TH + HYST.
  - Otherwise EXPECT if d < FAR_TH, or if Z != FAR and d < FAR_TH + HYST.
  - Otherwise FAR.
- Confirmation (zone register is the state machine: FAR, EXPECT, PET; any-to-any transition is legal, e.g. FAR -> PET directly):
  - Candidate c == Z: confirm counter cleared.
  - c != Z and c != previous candidate: counter = 1 and candidate register = c.
  - c != Z and c == previous candidate: counter increments.
  - When the counter value after this sample reaches CONFIRM: zone <= c, counter cleared, zone_change = 1 in the cycle zone updates.
  - Latency: zone updates on the clock edge that samples the CONFIRM-th agreeing dist_valid; the outputs reflect it from that edge onward. With CONFIRM = 1, any single differing sample commits.
  - Counter width is clog2(CONFIRM+1) and saturates; it never wraps.
- Timeout:
  - Counter increments every cycle and clears on each accepted sample.
  - On reaching TIMEOUT_CYC: stale = 1, zone <= FAR, confirm counter cleared, and the counter holds (saturates).
  - zone_change pulses only if zone was not already FAR.
  - stale clears on the edge that accepts the next sample; that sample is classified normally against zone = FAR.
- Simultaneous events: if an accepted sample arrives in the cycle the timeout would expire, the sample wins; no timeout occurs.
- zone_change is never asserted for two consecutive cycles unless zone really changes twice.
- petting and expecting are combinational decodes of registered zone, so they are glitch-free.

Test Plan:
- Reset, then three samples of d = 300 (default params) -> zone stays FAR after the 1st and 2nd; zone = PET, petting = expecting = 1 and zone_change pulses once after the 3rd.
- From PET, three samples of d = 520 (within NEAR_TH + HYST = 543) -> zone stays PET. Then three samples of d = 600 -> zone = EXPECT, petting = 0, expecting = 1.
- From FAR, samples 800, 800, 2000, 800, 800 -> no change. A 6th sample of 800 -> zone = EXPECT (counter restarted by 2000 then reached 3).
- Samples of d = 0 interleaved between 300, 300, 300 -> d = 0 ignored; zone = PET after the third 300.
- TIMEOUT_CYC = 100, zone = EXPECT, no dist_valid for 100 cycles -> zone = FAR, stale = 1, one zone_change. Next sample 2000 -> stale = 0, zone stays FAR.
- Assert rst mid-confirmation (2 of 3 PET samples seen) -> immediate zone = FAR, counter 0. After release, one 300 sample -> still FAR.
